// File: rtl/scan_select_gen.sv
// scan_select_gen: time-multiplexed select/enable generator for a 2-to-4 decoder.
// Steps sel 0->1->2->3->0, one slot of (div_q+1) clocks each, with BLANK
// enable-low clocks between slots. A masked slot keeps its full length with
// en held low, so the frame period does not depend on the mask.
// run is registered once; state changes follow the registered copy.
module scan_select_gen #(
   parameter int DIV_W = 16,
   parameter int BLANK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   input  logic [3:0]       mask,
   output logic [1:0]       sel,
   output logic             en,
   output logic             frame_done,
   output logic             busy
);

   localparam int GAP_W = (BLANK > 1) ? $clog2(BLANK) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((BLANK > 0) ? (BLANK - 1) : 0);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [DIV_W-1:0] SLOT_ONE = DIV_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic             run_r;
   logic [1:0]       sel_r, sel_s;
   logic             en_r, en_s;
   logic             frame_done_r, frame_done_s;
   logic             busy_r, busy_s;
   logic [DIV_W-1:0] slot_cnt_r, slot_cnt_s;
   logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
   logic [DIV_W-1:0] div_q_r, div_q_s;
   logic [3:0]       mask_q_r, mask_q_s;

   // Registers all state, counters, latched slot settings and outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         run_r        <= 1'b0;
         sel_r        <= 2'd0;
         en_r         <= 1'b0;
         frame_done_r <= 1'b0;
         busy_r       <= 1'b0;
         slot_cnt_r   <= {DIV_W{1'b0}};
         gap_cnt_r    <= {GAP_W{1'b0}};
         div_q_r      <= {DIV_W{1'b0}};
         mask_q_r     <= 4'b0000;
      end else begin
         state_r      <= state_s;
         run_r        <= run;
         sel_r        <= sel_s;
         en_r         <= en_s;
         frame_done_r <= frame_done_s;
         busy_r       <= busy_s;
         slot_cnt_r   <= slot_cnt_s;
         gap_cnt_r    <= gap_cnt_s;
         div_q_r      <= div_q_s;
         mask_q_r     <= mask_q_s;
      end
   end

   // Next-state logic; each SHOW entry latches div/mask and clears the slot counter.
   always_comb begin
      state_s    = state_r;
      sel_s      = sel_r;
      slot_cnt_s = slot_cnt_r;
      gap_cnt_s  = gap_cnt_r;
      div_q_s    = div_q_r;
      mask_q_s   = mask_q_r;
      case (state_r)
         ST_IDLE: begin
            if (run_r) begin
               state_s    = ST_SHOW;
               sel_s      = 2'd0;
               slot_cnt_s = {DIV_W{1'b0}};
               div_q_s    = div;
               mask_q_s   = mask;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHOW: begin
            if (!run_r) begin
               state_s = ST_IDLE;
            end else if (slot_cnt_r == div_q_r) begin
               if (BLANK > 0) begin
                  state_s   = ST_GAP;
                  gap_cnt_s = {GAP_W{1'b0}};
               end else begin
                  state_s    = ST_SHOW;
                  sel_s      = sel_r + 2'd1;
                  slot_cnt_s = {DIV_W{1'b0}};
                  div_q_s    = div;
                  mask_q_s   = mask;
               end
            end else begin
               slot_cnt_s = slot_cnt_r + SLOT_ONE;
            end
         end
         ST_GAP: begin
            if (!run_r) begin
               state_s = ST_IDLE;
            end else if (gap_cnt_r == GAP_LAST) begin
               state_s    = ST_SHOW;
               sel_s      = sel_r + 2'd1;
               slot_cnt_s = {DIV_W{1'b0}};
               div_q_s    = div;
               mask_q_s   = mask;
            end else begin
               gap_cnt_s = gap_cnt_r + GAP_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the next cycle, derived from the next state so they register cleanly.
   always_comb begin
      en_s         = 1'b0;
      busy_s       = 1'b0;
      frame_done_s = 1'b0;
      if (state_s == ST_SHOW) begin
         en_s = mask_q_s[sel_s];
      end else begin
         en_s = 1'b0;
      end
      busy_s = (state_s != ST_IDLE);
      // frame_done marks the very last cycle of slot 3 (its gap if there is one).
      if (BLANK > 0) begin
         frame_done_s = (state_s == ST_GAP) && (sel_s == 2'd3) && (gap_cnt_s == GAP_LAST);
      end else begin
         frame_done_s = (state_s == ST_SHOW) && (sel_s == 2'd3) && (slot_cnt_s == div_q_s);
      end
   end

   assign sel        = sel_r;
   assign en         = en_r;
   assign frame_done = frame_done_r;
   assign busy       = busy_r;

endmodule
